// File: rtl/rapid_pkg.sv
// Shared widths and types for the rapid core register file.
package rapid_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [XLEN-1:0]       word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the rapid register file; x0 and a low enable both read zero.
// Optional write-through forwarding is compiled in with RAPID_REGFILE_BYPASS_EN.
module regfile_read_port #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0]                 i_idx,
   input  logic                              i_en,
   input  logic [2**ADDR_W-1:1][DATA_W-1:0]  i_regs,
`ifdef RAPID_REGFILE_BYPASS_EN
   input  logic [ADDR_W-1:0]                 i_wr_idx,
   input  logic [DATA_W-1:0]                 i_wr_data,
`endif
   output logic [DATA_W-1:0]                 o_data
);

   // A zero i_wr_idx means no write this cycle, so it can never match a nonzero index.
   always_comb begin
      o_data = '0;
      if (i_en && (i_idx != '0)) begin
         o_data = i_regs[i_idx];
`ifdef RAPID_REGFILE_BYPASS_EN
         if (i_wr_idx == i_idx) begin
            o_data = i_wr_data;
         end
`endif
      end
   end

endmodule

// File: rtl/rapid_register_file.sv
// RV32 integer register file: 31 stored registers (x0 hardwired to zero), two gated read ports.
// Define RAPID_REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module rapid_register_file
   import rapid_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rs1_out,
   input  logic              i_rs2_out,
   input  logic [ADDR_W-1:0] i_rs1,
   input  logic [ADDR_W-1:0] i_rs2,
   input  logic [ADDR_W-1:0] i_rd,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic [DATA_W-1:0] o_rs1_data,
   output logic [DATA_W-1:0] o_rs2_data
);

   localparam int NUM_ENTRIES = 2**ADDR_W;

   logic [NUM_ENTRIES-1:1][DATA_W-1:0] regs_q;
   logic [NUM_ENTRIES-1:1][DATA_W-1:0] regs_d;

   always_comb begin
      regs_d = regs_q;
      if (i_rd != '0) begin
         regs_d[i_rd] = i_rd_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

`ifdef RAPID_REGFILE_BYPASS_EN
   // Forwarding is suppressed in reset so the ports still read zero while storage is held clear.
   logic [ADDR_W-1:0] wr_idx;
   assign wr_idx = i_reset ? i_rd : '0;
`endif

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rs1_port (
      .i_idx     (i_rs1),
      .i_en      (i_rs1_out),
      .i_regs    (regs_q),
`ifdef RAPID_REGFILE_BYPASS_EN
      .i_wr_idx  (wr_idx),
      .i_wr_data (i_rd_data),
`endif
      .o_data    (o_rs1_data)
   );

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rs2_port (
      .i_idx     (i_rs2),
      .i_en      (i_rs2_out),
      .i_regs    (regs_q),
`ifdef RAPID_REGFILE_BYPASS_EN
      .i_wr_idx  (wr_idx),
      .i_wr_data (i_rd_data),
`endif
      .o_data    (o_rs2_data)
   );

endmodule

// File: tb/tb_rapid_register_file.sv
// Directed scoreboard bench for rapid_register_file; expectations follow RAPID_REGFILE_BYPASS_EN.
module tb_rapid_register_file;
   import rapid_pkg::*;

   logic      i_clk = 1'b0;
   logic      i_reset = 1'b0;
   logic      i_rs1_out = 1'b0;
   logic      i_rs2_out = 1'b0;
   reg_addr_t i_rs1 = '0;
   reg_addr_t i_rs2 = '0;
   reg_addr_t i_rd = '0;
   word_t     i_rd_data = '0;
   word_t     o_rs1_data;
   word_t     o_rs2_data;

   string tag_q[$];
   word_t exp1_q[$];
   word_t exp2_q[$];
   int    tests_run = 0;
   int    tests_failed = 0;

   rapid_register_file dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_rs1_out  (i_rs1_out),
      .i_rs2_out  (i_rs2_out),
      .i_rs1      (i_rs1),
      .i_rs2      (i_rs2),
      .i_rd       (i_rd),
      .i_rd_data  (i_rd_data),
      .o_rs1_data (o_rs1_data),
      .o_rs2_data (o_rs2_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic applyStimulus(input string tag, input logic en1, input reg_addr_t rs1,
                                input logic en2, input reg_addr_t rs2,
                                input word_t exp1, input word_t exp2);
      i_rs1_out = en1;
      i_rs1     = rs1;
      i_rs2_out = en2;
      i_rs2     = rs2;
      tag_q.push_back(tag);
      exp1_q.push_back(exp1);
      exp2_q.push_back(exp2);
   endtask

   task automatic checkOutput();
      string tag;
      word_t exp1;
      word_t exp2;
      #1;
      tag  = tag_q.pop_front();
      exp1 = exp1_q.pop_front();
      exp2 = exp2_q.pop_front();
      tests_run++;
      assert (o_rs1_data === exp1) else begin
         tests_failed++;
         $error("[TB] FAIL %s rs1: observed=%h expected=%h", tag, o_rs1_data, exp1);
      end
      tests_run++;
      assert (o_rs2_data === exp2) else begin
         tests_failed++;
         $error("[TB] FAIL %s rs2: observed=%h expected=%h", tag, o_rs2_data, exp2);
      end
   endtask

   task automatic writeReg(input reg_addr_t rd, input word_t data);
      @(negedge i_clk);
      i_rd      = rd;
      i_rd_data = data;
      @(posedge i_clk);
      #1;
      i_rd      = '0;
   endtask

   initial begin
      word_t same_cycle_exp;

      // Reset held across edges, then released between edges.
      applyStimulus("in_reset", 1'b1, 5'd5, 1'b1, 5'd31, 32'h0, 32'h0);
      checkOutput();
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b1;
      applyStimulus("after_reset", 1'b1, 5'd5, 1'b1, 5'd31, 32'h0, 32'h0);
      checkOutput();

      // Walk every writable register, reading back on port 1 with port 2 disabled.
      for (int i = 1; i < 32; i++) begin
         writeReg(reg_addr_t'(i), word_t'(i * 3));
         applyStimulus($sformatf("walk_x%0d", i), 1'b1, reg_addr_t'(i), 1'b0, 5'd1,
                       word_t'(i * 3), 32'h0);
         checkOutput();
      end
      applyStimulus("both_ports", 1'b1, 5'd30, 1'b1, 5'd17, 32'd90, 32'd51);
      checkOutput();

      // Writes to x0 are dropped and x0 reads zero even when enabled.
      writeReg(5'd0, 32'hDEADBEEF);
      applyStimulus("x0_write", 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0);
      checkOutput();

      writeReg(5'd7, 32'h1234);
      applyStimulus("gate_rs2", 1'b1, 5'd7, 1'b0, 5'd7, 32'h1234, 32'h0);
      checkOutput();
      applyStimulus("gate_rs1", 1'b0, 5'd7, 1'b1, 5'd7, 32'h0, 32'h1234);
      checkOutput();

      // Same-cycle read of the register being written.
      writeReg(5'd9, 32'hAA);
`ifdef RAPID_REGFILE_BYPASS_EN
      same_cycle_exp = 32'h55;
`else
      same_cycle_exp = 32'hAA;
`endif
      @(negedge i_clk);
      i_rd      = 5'd9;
      i_rd_data = 32'h55;
      applyStimulus("raw_same_cycle", 1'b1, 5'd9, 1'b0, 5'd9, same_cycle_exp, 32'h0);
      checkOutput();
      @(posedge i_clk);
      #1;
      i_rd = '0;
      applyStimulus("raw_after_edge", 1'b1, 5'd9, 1'b1, 5'd9, 32'h55, 32'h55);
      checkOutput();

      // Fill, then pulse reset between edges with a write pending.
      for (int i = 1; i < 32; i++) begin
         writeReg(reg_addr_t'(i), 32'hA5A50000 | word_t'(i));
      end
      applyStimulus("filled", 1'b1, 5'd3, 1'b1, 5'd31, 32'hA5A50003, 32'hA5A5001F);
      checkOutput();
      @(negedge i_clk);
      #1;
      i_reset   = 1'b0;
      i_rd      = 5'd3;
      i_rd_data = 32'hFFFF_FFFF;
      applyStimulus("reset_pulse", 1'b1, 5'd3, 1'b1, 5'd31, 32'h0, 32'h0);
      checkOutput();
      @(posedge i_clk);
      applyStimulus("reset_blocks_write", 1'b1, 5'd3, 1'b1, 5'd12, 32'h0, 32'h0);
      checkOutput();
      @(negedge i_clk);
      i_rd    = '0;
      i_reset = 1'b1;
      applyStimulus("after_release", 1'b1, 5'd3, 1'b1, 5'd20, 32'h0, 32'h0);
      checkOutput();
      @(posedge i_clk);
      applyStimulus("after_release_edge", 1'b1, 5'd1, 1'b1, 5'd31, 32'h0, 32'h0);
      checkOutput();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
